spram_arbiter: RTL

- Round-robin arbiter and sequencer that shares one single-port RAM among NUM_REQ requesters.
- The RAM has a bidirectional data bus, r/w strobes and a 1-cycle registered read.
- Latches the winning request, drives the RAM strobes and address, and returns a done pulse plus read data.
- Sits between client blocks and the RAM instance; it is the only master of the RAM pins.

---
 rtl/spram_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/spram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spram_arbiter
// Description : Round-robin arbiter and sequencer that shares one single-port
//               RAM (1-cycle registered read, bidirectional data bus) among
//               NUM_REQ requesters. The winner's request is captured at
//               acceptance. The block then drives the RAM strobes, address and
//               data bus, and returns a one-hot done pulse plus read data.
//
// Ports       : clk, rst_n              clock, async active-low reset
//               req/we [NUM_REQ]        per-requester request level / write
//               addr/wdata (packed)     requester i at [i*W +: W]
//               gnt/done [NUM_REQ]      one-hot single-cycle pulses
//               rdata                   last completed read data (held)
//               ram_addr/ram_r/ram_w    RAM address and strobes
//               ram_data                RAM data bus (driven only while writing)
//
// Option      : `define SPRAM_ARB_FIXED_PRIO_EN makes requester 0 win whenever
//               it requests. Requesters 1..NUM_REQ-1 then rotate among
//               themselves.
//
// Revision    : 1.0 - initial release
// ============================================================================
module spram_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic                      ram_r,
    output logic                      ram_w,
    inout  wire  [DATA_W-1:0]         ram_data
);

    localparam int                 c_IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One extra bit so pointer + offset can exceed NUM_REQ before wrapping.
    localparam int                 c_CNT_W   = c_IDX_W + 1;
    localparam logic [c_IDX_W-1:0] c_PTR_RST = c_IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_ONE     = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR       = 2'd1,
        S_RD_ISSUE = 2'd2,
        S_RD_CAP   = 2'd3
    } state_t;

    state_t               r_state,  w_state_nx;
    logic [c_IDX_W-1:0]   r_ptr,    w_ptr_nx;
    logic [c_IDX_W-1:0]   r_win,    w_win_nx;
    logic [DATA_W-1:0]    r_wdata,  w_wdata_nx;
    logic                 r_drive,  w_drive_nx;
    logic [NUM_REQ-1:0]   w_gnt_nx, w_done_nx;
    logic [DATA_W-1:0]    w_rdata_nx;
    logic [ADDR_W-1:0]    w_ram_addr_nx;
    logic                 w_ram_r_nx, w_ram_w_nx;

    logic                 w_found;
    logic [c_IDX_W-1:0]   w_sel;
    logic [c_CNT_W-1:0]   w_cand;

    // ------------------------------------------------------------------
    // Winner selection: search upward from the requester after the last
    // winner, wrapping, so the last winner has lowest priority.
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
`ifdef SPRAM_ARB_FIXED_PRIO_EN
        if (req[0]) begin
            w_found = 1'b1;
        end else begin
            // Rotation among 1..NUM_REQ-1 only; the pointer never holds 0.
            for (int k = 1; k < NUM_REQ; k++) begin
                w_cand = {1'b0, r_ptr} + c_CNT_W'(k);
                if (w_cand > c_CNT_W'(NUM_REQ - 1)) begin
                    w_cand = w_cand - c_CNT_W'(NUM_REQ - 1);
                end
                if (!w_found && req[w_cand[c_IDX_W-1:0]]) begin
                    w_found = 1'b1;
                    w_sel   = w_cand[c_IDX_W-1:0];
                end
            end
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + c_CNT_W'(k);
            if (w_cand >= c_CNT_W'(NUM_REQ)) begin
                w_cand = w_cand - c_CNT_W'(NUM_REQ);
            end
            if (!w_found && req[w_cand[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[c_IDX_W-1:0];
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Every output is registered, so
    // the strobes for a state are computed on the way into that state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx    = r_state;
        w_ptr_nx      = r_ptr;
        w_win_nx      = r_win;
        w_wdata_nx    = r_wdata;
        w_drive_nx    = 1'b0;
        w_gnt_nx      = '0;
        w_done_nx     = '0;
        w_rdata_nx    = rdata;
        w_ram_addr_nx = ram_addr;
        w_ram_r_nx    = 1'b0;
        w_ram_w_nx    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_win_nx      = w_sel;
`ifdef SPRAM_ARB_FIXED_PRIO_EN
                    if (w_sel != '0) begin
                        w_ptr_nx = w_sel;
                    end
`else
                    w_ptr_nx      = w_sel;
`endif
                    w_gnt_nx      = c_ONE << w_sel;
                    w_ram_addr_nx = addr[w_sel*ADDR_W +: ADDR_W];
                    w_wdata_nx    = wdata[w_sel*DATA_W +: DATA_W];
                    if (we[w_sel]) begin
                        w_state_nx = S_WR;
                        w_ram_w_nx = 1'b1;
                        w_drive_nx = 1'b1;
                    end else begin
                        w_state_nx = S_RD_ISSUE;
                        w_ram_r_nx = 1'b1;
                    end
                end
            end
            S_WR: begin
                w_state_nx = S_IDLE;
                w_done_nx  = c_ONE << r_win;
            end
            S_RD_ISSUE: begin
                // RAM registers its output at the end of this cycle; keep
                // the strobe up through the capture cycle.
                w_state_nx = S_RD_CAP;
                w_ram_r_nx = 1'b1;
            end
            S_RD_CAP: begin
                w_state_nx = S_IDLE;
                w_rdata_nx = ram_data;
                w_done_nx  = c_ONE << r_win;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= c_PTR_RST;
            r_win    <= '0;
            r_wdata  <= '0;
            r_drive  <= 1'b0;
            gnt      <= '0;
            done     <= '0;
            rdata    <= '0;
            ram_addr <= '0;
            ram_r    <= 1'b0;
            ram_w    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_ptr    <= w_ptr_nx;
            r_win    <= w_win_nx;
            r_wdata  <= w_wdata_nx;
            r_drive  <= w_drive_nx;
            gnt      <= w_gnt_nx;
            done     <= w_done_nx;
            rdata    <= w_rdata_nx;
            ram_addr <= w_ram_addr_nx;
            ram_r    <= w_ram_r_nx;
            ram_w    <= w_ram_w_nx;
        end
    end

    // The bus enable is a flop cleared by reset, so an abort releases the
    // bus at once.
    assign ram_data = r_drive ? r_wdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire
